// File: rtl/pt_pkg.sv
// pt_pkg: shared types and constants for the plaintext reader.
// Holds the FSM state enum, memory layout and printable-ASCII bounds.
package pt_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEN_RD   = 3'd1,
        LEN_CAP  = 3'd2,
        BYTE_RD  = 3'd3,
        BYTE_CAP = 3'd4,
        SEND     = 3'd5
    } pt_state_e;

    localparam logic [7:0] LEN_ADDR  = 8'd0;
    localparam logic [7:0] ASCII_MIN = 8'h20;
    localparam logic [7:0] ASCII_MAX = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_MIN) && (b <= ASCII_MAX);
    endfunction

endpackage

// File: rtl/pt_reader.sv
// pt_reader: streams a length-prefixed string out of a sync-read memory.
// Define PT_ASCII_CHECK_EN to abort on non-printable bytes (bad_char).
module pt_reader
    import pt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       bad_char
);

    pt_state_e  state;
    pt_state_e  state_nx;
    logic [7:0] len;
    logic [7:0] idx;
    logic [7:0] data_q;
    logic       byte_ok;

`ifdef PT_ASCII_CHECK_EN
    logic bad_q;

    assign byte_ok  = is_printable(pt_rddata);
    assign bad_char = bad_q;

    // sticky abort flag, cleared when a new message is started
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_q <= 1'b0;
        end else if (state == IDLE && en) begin
            bad_q <= 1'b0;
        end else if (state == BYTE_CAP && !byte_ok) begin
            bad_q <= 1'b1;
        end
    end
`else
    assign byte_ok  = 1'b1;
    assign bad_char = 1'b0;
`endif

    assign out_data = data_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (en) state_nx = LEN_RD;
            end
            LEN_RD: begin
                state_nx = LEN_CAP;
            end
            LEN_CAP: begin
                state_nx = (pt_rddata == 8'd0) ? IDLE : BYTE_RD;
            end
            BYTE_RD: begin
                state_nx = BYTE_CAP;
            end
            BYTE_CAP: begin
                state_nx = byte_ok ? SEND : IDLE;
            end
            SEND: begin
                if (out_ready) state_nx = (idx == len) ? IDLE : BYTE_RD;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // length, index and output byte registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len    <= 8'd0;
            idx    <= 8'd0;
            data_q <= 8'd0;
        end else begin
            case (state)
                LEN_CAP: begin
                    len <= pt_rddata;
                    idx <= 8'd1;
                end
                BYTE_CAP: begin
                    if (byte_ok) data_q <= pt_rddata;
                end
                SEND: begin
                    // idx stops at len so a 255-byte message never wraps
                    if (out_ready && idx != len) idx <= idx + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the state
    always_comb begin
        rdy       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        pt_addr   = LEN_ADDR;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
            end
            LEN_RD: begin
                pt_addr = LEN_ADDR;
            end
            BYTE_RD: begin
                pt_addr = idx;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (idx == len);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pt_reader.sv
// tb_pt_reader: table vectors, directed corners and random messages.
// Build with or without PT_ASCII_CHECK_EN; expectations follow the macro.
module tb_pt_reader;

`ifdef PT_ASCII_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       bad_char;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 256x8 synchronous-read plaintext memory
    always @(posedge clk) pt_rddata <= mem[pt_addr];

    pt_reader dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .bad_char  (bad_char)
    );

    typedef struct {
        int             n;
        logic [0:3][7:0] b;
        int             ecnt;
        bit             ebad;
        int             erdy;
    } vec_t;

    vec_t tv [6];

    logic [7:0] got_q [$];
    bit         got_last [$];
    logic [7:0] exp_q [$];
    bit         exp_bad;
    int first_valid, rdy_cyc, stalls, stab_err, addr_err, max_addr;
    bit tmo;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Launch one message and observe it until rdy returns.
    task automatic run_msg(input int rpct, input int stall_first,
                           input bit noise, input int maxc);
        bit         pv, pr, pl, r;
        logic [7:0] pd;
        int         nvalid;
        got_q.delete();
        got_last.delete();
        first_valid = -1;
        rdy_cyc     = -1;
        stalls      = 0;
        stab_err    = 0;
        addr_err    = 0;
        max_addr    = 0;
        tmo         = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
        nvalid = 0;
        @(negedge clk);
        en        = 1'b1;
        out_ready = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (int'(pt_addr) > max_addr) max_addr = int'(pt_addr);
            if (rdy) begin
                rdy_cyc = c;
                break;
            end
            en = noise ? 1'($urandom_range(1)) : 1'b0;
            if (pv && !pr &&
                !(out_valid && out_data == pd && out_last == pl))
                stab_err++;
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (pt_addr != 8'd0) addr_err++;
                if (nvalid < stall_first) r = 1'b0;
                else r = ($urandom_range(99) < rpct);
                nvalid++;
                out_ready = r;
                if (r) begin
                    got_q.push_back(out_data);
                    got_last.push_back(out_last);
                end else begin
                    stalls++;
                end
            end else begin
                out_ready = 1'($urandom_range(1));
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pl = out_last;
        end
        if (rdy_cyc < 0) tmo = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
    endtask

    // Reference: the bytes pt[1..n], cut at the first unprintable one
    // when the check is enabled.
    task automatic model(input int n);
        exp_q.delete();
        exp_bad = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (CHK && (mem[k] < 8'h20 || mem[k] > 8'h7E)) begin
                exp_bad = 1'b1;
                break;
            end
            exp_q.push_back(mem[k]);
        end
    endtask

    task automatic compare(input string tag, input int n);
        int cnt;
        int m;
        model(n);
        cnt = exp_q.size();
        chk({tag, " timeout"}, int'(tmo), 0);
        chk({tag, " count"}, got_q.size(), cnt);
        m = (got_q.size() < cnt) ? got_q.size() : cnt;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
            chk($sformatf("%s last%0d", tag, i), int'(got_last[i]),
                int'(!exp_bad && i == n - 1));
        end
        chk({tag, " bad_char"}, int'(bad_char), int'(exp_bad));
        chk({tag, " rdy_cycle"}, rdy_cyc,
            3 + 3 * cnt + (exp_bad ? 2 : 0) + stalls);
        chk({tag, " first_valid"}, first_valid, (cnt > 0) ? 5 : -1);
        chk({tag, " stable"}, stab_err, 0);
        chk({tag, " addr_in_send"}, addr_err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         seen;
        int         n;
        logic [7:0] b2;
        bit         hit;

        tv[0] = '{3, {8'h03, 8'h41, 8'h42, 8'h43}, 3, 1'b0, 12};
        tv[1] = '{0, {8'h00, 8'h41, 8'h42, 8'h43}, 0, 1'b0, 3};
        tv[2] = '{1, {8'h01, 8'h7E, 8'h00, 8'h00}, 1, 1'b0, 6};
`ifdef PT_ASCII_CHECK_EN
        tv[3] = '{2, {8'h02, 8'h20, 8'h7F, 8'h00}, 1, 1'b1, 8};
        tv[4] = '{3, {8'h03, 8'h41, 8'h07, 8'h43}, 1, 1'b1, 8};
        tv[5] = '{1, {8'h01, 8'h1F, 8'h00, 8'h00}, 0, 1'b1, 5};
`else
        tv[3] = '{2, {8'h02, 8'h20, 8'h7F, 8'h00}, 2, 1'b0, 9};
        tv[4] = '{3, {8'h03, 8'h41, 8'h07, 8'h43}, 3, 1'b0, 12};
        tv[5] = '{1, {8'h01, 8'h1F, 8'h00, 8'h00}, 1, 1'b0, 6};
`endif

        clear_mem();
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rdy", int'(rdy), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_last", int'(out_last), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset pt_addr", int'(pt_addr), 0);
        chk("reset bad_char", int'(bad_char), 0);
        rst = 1'b0;

        // table vectors with the sink always ready
        for (int t = 0; t < 6; t++) begin
            clear_mem();
            for (int k = 0; k < 4; k++) mem[k] = tv[t].b[k];
            run_msg(100, 0, 1'b0, 100);
            chk($sformatf("tv%0d timeout", t), int'(tmo), 0);
            chk($sformatf("tv%0d count", t), got_q.size(), tv[t].ecnt);
            for (int i = 0; i < got_q.size() && i < tv[t].ecnt; i++) begin
                chk($sformatf("tv%0d byte%0d", t, i),
                    int'(got_q[i]), int'(tv[t].b[i + 1]));
                chk($sformatf("tv%0d last%0d", t, i), int'(got_last[i]),
                    int'(!tv[t].ebad && i == tv[t].ecnt - 1));
            end
            chk($sformatf("tv%0d bad_char", t), int'(bad_char), int'(tv[t].ebad));
            chk($sformatf("tv%0d rdy_cycle", t), rdy_cyc, tv[t].erdy);
            chk($sformatf("tv%0d first_valid", t), first_valid,
                (tv[t].ecnt > 0) ? 5 : -1);
        end

        // four-cycle stall on the first byte
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h61; mem[2] = 8'h62;
        run_msg(100, 4, 1'b0, 60);
        chk("stall stalls", stalls, 4);
        chk("stall stable", stab_err, 0);
        chk("stall addr_in_send", addr_err, 0);
        chk("stall count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("stall byte0", int'(got_q[0]), 8'h61);
            chk("stall byte1", int'(got_q[1]), 8'h62);
        end
        chk("stall rdy_cycle", rdy_cyc, 13);

        // full 255-byte message
        clear_mem();
        mem[0] = 8'hFF;
        for (int k = 1; k < 256; k++) mem[k] = 8'((k % 95) + 32);
        run_msg(100, 0, 1'b0, 900);
        compare("long", 255);
        chk("long max_addr", max_addr, 255);

        // reset while the second of five bytes is offered
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'h48; mem[2] = 8'h45;
        mem[3] = 8'h4C; mem[4] = 8'h4C; mem[5] = 8'h4F;
        seen = 0;
        hit  = 1'b0;
        b2   = 8'h00;
        @(negedge clk);
        en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            en        = 1'b0;
            out_ready = 1'b1;
            if (out_valid) begin
                if (seen == 1) begin
                    b2        = out_data;
                    rst       = 1'b1;
                    out_ready = 1'b0;
                    hit       = 1'b1;
                    break;
                end
                seen++;
            end
        end
        chk("midrst reached", int'(hit), 1);
        chk("midrst byte2", int'(b2), 8'h45);
        @(negedge clk);
        chk("midrst rdy", int'(rdy), 1);
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst out_data", int'(out_data), 0);
        chk("midrst pt_addr", int'(pt_addr), 0);
        rst = 1'b0;
        run_msg(100, 0, 1'b0, 100);
        compare("restart", 5);

        // random messages, random backpressure, en noise while busy
        for (int it = 0; it < 40; it++) begin
            clear_mem();
            n = $urandom_range(24);
            mem[0] = 8'(n);
            for (int k = 1; k <= n; k++) begin
                if ($urandom_range(9) == 0) mem[k] = 8'($urandom_range(255));
                else mem[k] = 8'($urandom_range(8'h7E, 8'h20));
            end
            run_msg($urandom_range(100, 30), 0, 1'b1, 3000);
            compare($sformatf("rand%0d", it), n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
